field_rmw_sequencer: RTL and testbench
======================================

Name: field_rmw_sequencer

Overview:
- Initiator for the field-accessor protocol (fieldGo/wryt/fieldNum/structIn/fieldIn -> structOut/fieldOut).
- Accepts READ, WRITE and ADD commands against one 128-bit hITEM binary image and drives the accessor with correctly timed pulses and held operands.
- Returns the updated structure and field value.
- Sits between the page/book maintenance logic and the accessor instance.

Parameters:
TGT_BITS, 64, target bus width; structure is 2*TGT_BITS.

Ports:
clk  in  1  clock
rsta  in  1  reset, asynchronous, active-high
cmdValid  in  1  command offered
cmdReady  out  1  command accepted when cmdValid&&cmdReady
cmdOp  in  2  0=READ, 1=WRITE, 2=ADD, 3=illegal
cmdField  in  4  FLD_* selector
cmdStruct  in  2*TGT_BITS  hITEM binary image
cmdValue  in  TGT_BITS  write value, or signed delta for ADD
rspValid  out  1  response held until rspReady
rspReady  in  1  response consumed
rspStruct  out  2*TGT_BITS  resulting structure
rspField  out  TGT_BITS  field value read or written
rspOvf  out  1  ADD result not representable in field width
rspErr  out  1  illegal op or field; nothing issued
fGo  out  1  to accessor fieldGo
fWryt  out  1  to accessor wryt
fNum  out  4  to accessor fieldNum
fStructIn  out  2*TGT_BITS  to accessor structIn
fFieldIn  out  TGT_BITS  to accessor fieldIn
fStructOut  in  2*TGT_BITS  from accessor structOut
fFieldOut  in  TGT_BITS  from accessor fieldOut

Behaviour:
- Reset (async): state IDLE.
  - cmdReady=0 while rsta asserted, 1 in IDLE after release.
  - rspValid, rspOvf, rspErr, fGo, fWryt = 0.
  - All data registers = 0.
- Accessor contract:
  - Read data is valid on fFieldOut one cycle after fGo.
  - Write: the accessor copies the structure one cycle after fGo and applies the field one cycle later. fNum and fFieldIn must be held through both cycles. fStructOut is final 2 cycles after fGo.
- All outputs are registered. cmdReady=1 only in IDLE.
- On accept, latch op, field, struct and value. fStructIn and fNum are driven from the latched copies for the whole operation.
- States: IDLE, RD_GO, RD_CAP, WR_GO, WR_HOLD, WR_CAP, RESP.
- Cycle numbering: accept cycle = 0.
- READ:
  - RD_GO (c1): fGo=1, fWryt=0.
  - RD_CAP (c2): capture fFieldOut.
  - RESP (c3): rspStruct = latched struct.
- WRITE:
  - WR_GO (c1): fGo=1, fWryt=1.
  - WR_HOLD (c2).
  - WR_CAP (c3): capture fStructOut.
  - RESP (c4): rspField = value masked to field width.
- ADD:
  - RD_GO (c1).
  - RD_CAP (c2): sum = fFieldOut + sign-extended cmdValue, registered.
  - WR_GO (c3), WR_HOLD (c4), WR_CAP (c5).
  - RESP (c6): rspField = sum masked to field width.
  - rspOvf=1 if sum < 0 or sum >= 2^w. The truncated value is still written.
- Field widths w:
  - FLD_DATA = hUSER_ADR_BITS
  - FLD_STOP = 1
  - FLD_P1 / FLD_P2 = 46, byte address; bits [7:0] are dropped by the accessor.
  - FLD_COUNT = hCOUNT_BITS
  - FLD_TOTAL = 40
- ADD on FLD_P1/FLD_P2 with delta[7:0] != 0: rspErr=1, write still performed.
- Illegal op or unknown field: IDLE -> RESP at c1 with rspErr=1. No fGo. rspStruct = cmdStruct, rspField = 0.
- fGo is high for exactly one cycle per GO state. It is never asserted in IDLE, RESP or HOLD states.
- RESP:
  - rspValid=1; all rsp* outputs are stable until rspReady.
  - On rspValid&&rspReady: go to IDLE, rspValid=0.
  - cmdReady=1 the following cycle. No same-cycle accept; throughput is one command per latency+1.
- cmdValid during a busy operation: ignored, not accepted, no side effect.
- Reset mid-operation: immediate return to IDLE. Any in-flight accessor write is discarded; the accessor shares rsta.

Decomposition:
- Shared package (samDefines):
  - FLD_* codes.
  - OP_READ / OP_WRITE / OP_ADD.
  - hUSER_ADR_BITS, hCOUNT_BITS.
  - function fieldWidth(fieldNum) returning w, or 0 for unknown.
- No sub-module. The accessor is instantiated alongside in the parent, not inside this block.

Test Plan:
- READ FLD_COUNT, struct count=0x1234 -> fGo pulse at c1 with fWryt=0; rspValid at c3; rspField=0x1234; rspStruct==cmdStruct; rspOvf=0; rspErr=0.
- WRITE FLD_P1, value=0x0000_1234_5600 -> fGo at c1; fNum/fFieldIn stable c1-c2; rspValid at c4; rspField=0x1234_5600; rspStruct p1 field = 0x123456, p1_hi=0.
- ADD FLD_TOTAL, total=0xFF_FFFF_FFFF, delta=+1 -> rspValid at c6; rspField=0; rspOvf=1; struct total bytes all zero.
- ADD FLD_COUNT, count=5, delta=-3 -> rspField=2, rspOvf=0. Then with delta=-6 -> rspOvf=1.
- cmdOp=3 -> rspValid at c1, rspErr=1, no fGo. Hold rspReady=0 for 5 cycles -> outputs stable; cmdReady=0 throughout.
- Assert rsta during WR_HOLD of a WRITE -> same cycle: fGo=0, rspValid=0, state IDLE. After release, cmdReady=1 and a new READ completes normally.

Source files
------------

// File: rtl/field_rmw_sequencer_pkg.sv
// rtl/field_rmw_sequencer_pkg.sv - shared field codes, op codes, widths and FSM states for the field RMW sequencer
package field_rmw_sequencer_pkg;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_ADD   = 2'd2;

   localparam logic [3:0] FLD_DATA  = 4'd0;
   localparam logic [3:0] FLD_STOP  = 4'd1;
   localparam logic [3:0] FLD_P1    = 4'd2;
   localparam logic [3:0] FLD_P2    = 4'd3;
   localparam logic [3:0] FLD_COUNT = 4'd4;
   localparam logic [3:0] FLD_TOTAL = 4'd5;

   localparam int hUSER_ADR_BITS = 16;
   localparam int hCOUNT_BITS    = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_GO,
      S_RD_CAP,
      S_WR_GO,
      S_WR_HOLD,
      S_WR_CAP,
      S_RESP
   } state_t;

   // Architectural width of a field as seen by the accessor; 0 marks an unknown selector.
   // P1/P2 are byte addresses: 46 bits wide, the accessor drops bits [7:0].
   function automatic logic [6:0] fieldWidth(input logic [3:0] fieldNum);
      logic [6:0] w;
      case (fieldNum)
         FLD_DATA:  w = 7'(hUSER_ADR_BITS);
         FLD_STOP:  w = 7'd1;
         FLD_P1:    w = 7'd46;
         FLD_P2:    w = 7'd46;
         FLD_COUNT: w = 7'(hCOUNT_BITS);
         FLD_TOTAL: w = 7'd40;
         default:   w = 7'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/field_rmw_sequencer.sv
// rtl/field_rmw_sequencer.sv - READ/WRITE/ADD initiator driving the field accessor with timed pulses and held operands
module field_rmw_sequencer
   import field_rmw_sequencer_pkg::*;
#(
   parameter int TGT_BITS = 64
) (
   input  logic                    clk,
   input  logic                    rsta,
   input  logic                    cmdValid,
   output logic                    cmdReady,
   input  logic [1:0]              cmdOp,
   input  logic [3:0]              cmdField,
   input  logic [2*TGT_BITS-1:0]   cmdStruct,
   input  logic [TGT_BITS-1:0]     cmdValue,
   output logic                    rspValid,
   input  logic                    rspReady,
   output logic [2*TGT_BITS-1:0]   rspStruct,
   output logic [TGT_BITS-1:0]     rspField,
   output logic                    rspOvf,
   output logic                    rspErr,
   output logic                    fGo,
   output logic                    fWryt,
   output logic [3:0]              fNum,
   output logic [2*TGT_BITS-1:0]   fStructIn,
   output logic [TGT_BITS-1:0]     fFieldIn,
   input  logic [2*TGT_BITS-1:0]   fStructOut,
   input  logic [TGT_BITS-1:0]     fFieldOut
);

   state_t state;
   state_t state_next;

   logic go_next;
   logic wryt_next;
   logic rsp_valid_next;
   logic cmd_ready_next;

   logic [1:0]          op_q;
   logic [TGT_BITS-1:0] field_q;

   logic                accept;
   logic                illegal;
   logic [6:0]          cmd_w;
   logic [6:0]          cur_w;
   logic [TGT_BITS-1:0] cmd_mask;
   logic [TGT_BITS-1:0] cur_mask;
   logic [TGT_BITS+1:0] sum_ext;
   logic                sum_ovf;

   assign accept   = cmdValid && cmdReady;
   assign cmd_w    = fieldWidth(cmdField);
   assign cur_w    = fieldWidth(fNum);
   assign illegal  = (cmdOp == 2'd3) || (cmd_w == 7'd0);
   assign cmd_mask = (TGT_BITS'(1) << cmd_w) - TGT_BITS'(1);
   assign cur_mask = (TGT_BITS'(1) << cur_w) - TGT_BITS'(1);

   // field_q holds the signed delta until the read returns; the sum carries two guard bits
   // so both a negative result and a carry past the field width are visible.
   assign sum_ext  = {2'b00, fFieldOut} + {{2{field_q[TGT_BITS-1]}}, field_q};
   assign sum_ovf  = sum_ext[TGT_BITS+1] | sum_ext[TGT_BITS] |
                     (|(sum_ext[TGT_BITS-1:0] & ~cur_mask));

   // field_q is the value presented to the accessor and also the returned field value
   assign fFieldIn = field_q;
   assign rspField = field_q;

   // State register and registered control outputs
   always_ff @(posedge clk or posedge rsta) begin
      if (rsta) begin
         state    <= S_IDLE;
         fGo      <= 1'b0;
         fWryt    <= 1'b0;
         rspValid <= 1'b0;
         cmdReady <= 1'b0;
      end else begin
         state    <= state_next;
         fGo      <= go_next;
         fWryt    <= wryt_next;
         rspValid <= rsp_valid_next;
         cmdReady <= cmd_ready_next;
      end
   end

   // Next-state sequencing; control outputs are decoded from the next state so they register cleanly
   always_comb begin
      state_next     = state;
      go_next        = 1'b0;
      wryt_next      = 1'b0;
      rsp_valid_next = 1'b0;
      cmd_ready_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (illegal)
                  state_next = S_RESP;
               else if (cmdOp == OP_WRITE)
                  state_next = S_WR_GO;
               else
                  state_next = S_RD_GO;
            end
         end
         S_RD_GO:   state_next = S_RD_CAP;
         S_RD_CAP:  state_next = (op_q == OP_ADD) ? S_WR_GO : S_RESP;
         S_WR_GO:   state_next = S_WR_HOLD;
         S_WR_HOLD: state_next = S_WR_CAP;
         S_WR_CAP:  state_next = S_RESP;
         S_RESP: begin
            if (rspValid && rspReady)
               state_next = S_IDLE;
         end
         default:   state_next = S_IDLE;
      endcase
      go_next        = (state_next == S_RD_GO) || (state_next == S_WR_GO);
      wryt_next      = (state_next == S_WR_GO);
      rsp_valid_next = (state_next == S_RESP);
      cmd_ready_next = (state_next == S_IDLE);
   end

   // Operand latching, read capture, ADD sum and write-back capture
   always_ff @(posedge clk or posedge rsta) begin
      if (rsta) begin
         op_q      <= 2'd0;
         field_q   <= '0;
         fNum      <= 4'd0;
         fStructIn <= '0;
         rspStruct <= '0;
         rspOvf    <= 1'b0;
         rspErr    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q      <= cmdOp;
                  fNum      <= cmdField;
                  fStructIn <= cmdStruct;
                  rspStruct <= cmdStruct;
                  rspOvf    <= 1'b0;
                  rspErr    <= 1'b0;
                  if (illegal) begin
                     field_q <= '0;
                     rspErr  <= 1'b1;
                  end else begin
                     case (cmdOp)
                        OP_READ:  field_q <= '0;
                        OP_WRITE: field_q <= cmdValue & cmd_mask;
                        OP_ADD: begin
                           field_q <= cmdValue;
                           // address fields cannot take a sub-byte delta; flag it but still write
                           rspErr  <= ((cmdField == FLD_P1) || (cmdField == FLD_P2)) &&
                                      (cmdValue[7:0] != 8'h00);
                        end
                        default:  field_q <= '0;
                     endcase
                  end
               end
            end
            S_RD_CAP: begin
               if (op_q == OP_ADD) begin
                  field_q <= sum_ext[TGT_BITS-1:0] & cur_mask;
                  rspOvf  <= sum_ovf;
               end else begin
                  field_q <= fFieldOut;
               end
            end
            S_WR_CAP:  rspStruct <= fStructOut;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_field_rmw_sequencer.sv
// tb/tb_field_rmw_sequencer.sv - table-driven bench for field_rmw_sequencer with a toy accessor model
module tb_field_rmw_sequencer;
   import field_rmw_sequencer_pkg::*;

   logic         clk;
   logic         rsta;
   logic         cmdValid;
   logic         cmdReady;
   logic [1:0]   cmdOp;
   logic [3:0]   cmdField;
   logic [127:0] cmdStruct;
   logic [63:0]  cmdValue;
   logic         rspValid;
   logic         rspReady;
   logic [127:0] rspStruct;
   logic [63:0]  rspField;
   logic         rspOvf;
   logic         rspErr;
   logic         fGo;
   logic         fWryt;
   logic [3:0]   fNum;
   logic [127:0] fStructIn;
   logic [63:0]  fFieldIn;
   logic [127:0] fStructOut;
   logic [63:0]  fFieldOut;

   int total;
   int bad;

   field_rmw_sequencer #(.TGT_BITS(64)) dut (
      .clk(clk), .rsta(rsta),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdField(cmdField),
      .cmdStruct(cmdStruct), .cmdValue(cmdValue),
      .rspValid(rspValid), .rspReady(rspReady), .rspStruct(rspStruct), .rspField(rspField),
      .rspOvf(rspOvf), .rspErr(rspErr),
      .fGo(fGo), .fWryt(fWryt), .fNum(fNum), .fStructIn(fStructIn), .fFieldIn(fFieldIn),
      .fStructOut(fStructOut), .fFieldOut(fFieldOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Toy accessor layout: data[15:0] stop[16] count[32:17] total[72:33] p1>>8 [110:73]; P2 not stored
   function automatic logic [127:0] build(input logic [15:0] d, input logic st, input logic [15:0] cnt,
                                          input logic [39:0] tot, input logic [45:0] p1b);
      logic [127:0] s;
      s = '0;
      s[127:111] = 17'h0A5A5;
      s[15:0]    = d;
      s[16]      = st;
      s[32:17]   = cnt;
      s[72:33]   = tot;
      s[110:73]  = p1b[45:8];
      return s;
   endfunction

   function automatic logic [63:0] acc_get(input logic [127:0] s, input logic [3:0] n);
      logic [63:0] v;
      v = '0;
      case (n)
         FLD_DATA:  v[15:0]  = s[15:0];
         FLD_STOP:  v[0]     = s[16];
         FLD_COUNT: v[15:0]  = s[32:17];
         FLD_TOTAL: v[39:0]  = s[72:33];
         FLD_P1:    v[45:8]  = s[110:73];
         default:   v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [127:0] acc_put(input logic [127:0] s, input logic [3:0] n, input logic [63:0] v);
      logic [127:0] r;
      r = s;
      case (n)
         FLD_DATA:  r[15:0]   = v[15:0];
         FLD_STOP:  r[16]     = v[0];
         FLD_COUNT: r[32:17]  = v[15:0];
         FLD_TOTAL: r[72:33]  = v[39:0];
         FLD_P1:    r[110:73] = v[45:8];
         default:   r = s;
      endcase
      return r;
   endfunction

   logic         pend;
   logic [3:0]   p_num;
   logic [63:0]  p_field;
   int           hold_err;

   // Accessor: read data one cycle after fGo; write copies struct, then applies field a cycle later
   always @(posedge clk or posedge rsta) begin
      if (rsta) begin
         fFieldOut  <= '0;
         fStructOut <= '0;
         pend       <= 1'b0;
         p_num      <= '0;
         p_field    <= '0;
      end else begin
         if (fGo)
            fFieldOut <= acc_get(fStructIn, fNum);
         if (pend) begin
            fStructOut <= acc_put(fStructOut, fNum, fFieldIn);
            if (fNum != p_num || fFieldIn != p_field)
               hold_err <= hold_err + 1;
         end
         if (fGo && fWryt) begin
            fStructOut <= fStructIn;
            p_num      <= fNum;
            p_field    <= fFieldIn;
         end
         pend <= fGo && fWryt;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [3:0]   fld;
      logic [127:0] st;
      logic [63:0]  val;
      logic [63:0]  ef;
      logic [127:0] es;
      logic         eovf;
      logic         eerr;
      int           lat;
      int           gos;
   } vec_t;

   vec_t vecs[12];

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cmdReady && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmdReady) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got cmdReady=0 want 1");
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx, input bit hold_valid);
      int lat;
      int gos;
      int busy_rdy;
      wait_ready();
      cmdValid  = 1'b1;
      cmdOp     = v.op;
      cmdField  = v.fld;
      cmdStruct = v.st;
      cmdValue  = v.val;
      @(posedge clk); #1;
      cmdValid = hold_valid;
      lat = 1;
      gos = 0;
      busy_rdy = 0;
      while (!rspValid && lat < 20) begin
         if (fGo) gos++;
         if (cmdReady) busy_rdy++;
         @(posedge clk); #1;
         lat++;
      end
      cmdValid = 1'b0;
      chk($sformatf("v%0d_latency", idx), 128'(lat), 128'(v.lat));
      chk($sformatf("v%0d_go_count", idx), 128'(gos), 128'(v.gos));
      chk($sformatf("v%0d_field", idx), 128'(rspField), 128'(v.ef));
      chk($sformatf("v%0d_struct", idx), rspStruct, v.es);
      chk($sformatf("v%0d_ovf_err", idx), 128'({rspOvf, rspErr}), 128'({v.eovf, v.eerr}));
      if (hold_valid)
         chk($sformatf("v%0d_busy_ready", idx), 128'(busy_rdy), 128'd0);
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      chk($sformatf("v%0d_after_rsp", idx), 128'({rspValid, cmdReady}), 128'(2'b01));
   endtask

   logic [127:0] b0;

   initial begin
      total = 0;
      bad = 0;
      hold_err = 0;
      rsta = 1'b1;
      cmdValid = 1'b0;
      cmdOp = '0;
      cmdField = '0;
      cmdStruct = '0;
      cmdValue = '0;
      rspReady = 1'b0;

      b0 = build(16'hBEEF, 1'b1, 16'h1234, 40'h12_3456_789A, 46'h0000_ABCD_EF00);

      vecs[0]  = '{OP_READ,  FLD_COUNT, b0, 64'h0, 64'h1234, b0, 1'b0, 1'b0, 3, 1};
      vecs[1]  = '{OP_WRITE, FLD_P1, b0, 64'h0000_1234_5600, 64'h1234_5600,
                   build(16'hBEEF, 1'b1, 16'h1234, 40'h12_3456_789A, 46'h0000_1234_5600), 1'b0, 1'b0, 4, 1};
      vecs[2]  = '{OP_ADD, FLD_TOTAL, build(16'hBEEF, 1'b1, 16'h1234, 40'hFF_FFFF_FFFF, 46'h0000_ABCD_EF00),
                   64'h1, 64'h0, build(16'hBEEF, 1'b1, 16'h1234, 40'h0, 46'h0000_ABCD_EF00), 1'b1, 1'b0, 6, 2};
      vecs[3]  = '{OP_ADD, FLD_COUNT, build(16'hBEEF, 1'b1, 16'h0005, 40'h1, 46'h0),
                   64'hFFFF_FFFF_FFFF_FFFD, 64'h2, build(16'hBEEF, 1'b1, 16'h0002, 40'h1, 46'h0), 1'b0, 1'b0, 6, 2};
      vecs[4]  = '{OP_ADD, FLD_COUNT, build(16'hBEEF, 1'b1, 16'h0005, 40'h1, 46'h0),
                   64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF, build(16'hBEEF, 1'b1, 16'hFFFF, 40'h1, 46'h0), 1'b1, 1'b0, 6, 2};
      vecs[5]  = '{OP_ADD, FLD_COUNT, build(16'h0, 1'b0, 16'hFFFE, 40'h0, 46'h0),
                   64'h1, 64'hFFFF, build(16'h0, 1'b0, 16'hFFFF, 40'h0, 46'h0), 1'b0, 1'b0, 6, 2};
      vecs[6]  = '{OP_READ,  FLD_DATA, b0, 64'h0, 64'hBEEF, b0, 1'b0, 1'b0, 3, 1};
      vecs[7]  = '{OP_WRITE, FLD_STOP, b0, 64'h2, 64'h0,
                   build(16'hBEEF, 1'b0, 16'h1234, 40'h12_3456_789A, 46'h0000_ABCD_EF00), 1'b0, 1'b0, 4, 1};
      vecs[8]  = '{OP_ADD, FLD_P1, b0, 64'h100, 64'hABCD_F000,
                   build(16'hBEEF, 1'b1, 16'h1234, 40'h12_3456_789A, 46'h0000_ABCD_F000), 1'b0, 1'b0, 6, 2};
      vecs[9]  = '{OP_ADD, FLD_P1, b0, 64'h101, 64'hABCD_F001,
                   build(16'hBEEF, 1'b1, 16'h1234, 40'h12_3456_789A, 46'h0000_ABCD_F000), 1'b0, 1'b1, 6, 2};
      vecs[10] = '{OP_READ, 4'd9, b0, 64'h0, 64'h0, b0, 1'b0, 1'b1, 1, 0};
      vecs[11] = '{OP_WRITE, FLD_TOTAL, b0, 64'hFFFF_FF12_3456_789A, 64'h12_3456_789A,
                   build(16'hBEEF, 1'b1, 16'h1234, 40'h12_3456_789A, 46'h0000_ABCD_EF00), 1'b0, 1'b0, 4, 1};

      // reset state
      #2;
      chk("reset_ctrl", 128'({cmdReady, rspValid, rspOvf, rspErr, fGo, fWryt}), 128'd0);
      chk("reset_data", 128'({rspField, fFieldIn}), 128'd0);
      chk("reset_struct", rspStruct | fStructIn, 128'd0);
      @(posedge clk); #1;
      rsta = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", 128'(cmdReady), 128'd1);

      for (int i = 0; i < 12; i++)
         run_vec(vecs[i], i, (i == 1));

      // illegal op: immediate response, held stable while rspReady stays low
      wait_ready();
      cmdValid  = 1'b1;
      cmdOp     = 2'd3;
      cmdField  = FLD_COUNT;
      cmdStruct = b0;
      cmdValue  = 64'h55;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      chk("illegal_c1", 128'({rspValid, rspErr, rspOvf, cmdReady, fGo}), 128'(5'b11000));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("illegal_hold%0d", k),
             128'({rspValid, rspErr, cmdReady, fGo, (rspStruct == b0), (rspField == 64'h0)}),
             128'(6'b110011));
      end
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      chk("illegal_release", 128'({rspValid, cmdReady}), 128'(2'b01));

      // reset during WR_HOLD of a write
      cmdValid  = 1'b1;
      cmdOp     = OP_WRITE;
      cmdField  = FLD_DATA;
      cmdStruct = b0;
      cmdValue  = 64'h7777;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      chk("mid_wr_go", 128'({fGo, fWryt}), 128'(2'b11));
      @(posedge clk); #1;
      rsta = 1'b1;
      #1;
      chk("mid_reset_outs", 128'({fGo, fWryt, rspValid, cmdReady}), 128'd0);
      @(posedge clk); #1;
      rsta = 1'b0;
      @(posedge clk); #1;
      chk("mid_reset_ready", 128'(cmdReady), 128'd1);
      run_vec(vecs[0], 100, 1'b0);

      chk("operand_hold", 128'(hold_err), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
